// File: rtl/rca_pipe_pkg.sv
// Shared sizing helpers and the full-adder cell for the pipelined ripple-carry adder.
package rca_pipe_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Bits of the carry chain handled per pipeline stage.
    function automatic int chunk_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Stages that actually hold adder bits; any further stages only carry data.
    function automatic int n_slices(input int width, input int stages);
        int cw;
        cw = chunk_w(width, stages);
        return (width + cw - 1) / cw;
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/h_rca_slice.sv
// Combinational CW-bit ripple-carry slice; also exposes the carry into its MSB
// so the top slice can form the two's-complement overflow.
module h_rca_slice
    import rca_pipe_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        c_msb = cin;
        sum   = '0;
        for (int i = 0; i < CW; i++) begin
            if (i == CW - 1) c_msb = c;
            {c, sum[i]} = fa(a[i], b[i], c);
        end
        cout = c;
    end

endmodule

// File: rtl/h_rca_pipe.sv
// Pipelined ripple-carry adder: out = a + b + cin in WIDTH+1 bits, one carry-chain
// slice per stage, valid/ready handshake with a combinational stall chain.
module h_rca_pipe
    import rca_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             ovf
);

    localparam int CW = chunk_w(WIDTH, STAGES);
    localparam int NS = n_slices(WIDTH, STAGES);

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] vin;

    // Index k is the input side of stage k; index STAGES is the output register.
    logic [WIDTH-1:0] a_p [STAGES];
    logic [WIDTH-1:0] b_p [STAGES];
    logic [WIDTH-1:0] s_p [STAGES+1];
    logic             c_p [STAGES+1];
    logic             o_p [STAGES+1];

    assign a_p[0] = a;
    assign b_p[0] = b;
    assign s_p[0] = '0;
    assign c_p[0] = cin;
    assign o_p[0] = 1'b0;

    // A stage loads when it is empty or its occupant moves on this cycle.
    always_comb begin
        logic go;
        go = out_ready;
        ld = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go    = ~vld_p[k] | go;
            ld[k] = go;
        end
    end

    assign vin = STAGES'({vld_p, in_valid});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= (ld & vin) | (~ld & vld_p);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             en;
        logic [WIDTH-1:0] s_nx;
        logic [WIDTH-1:0] s_q;
        logic             c_nx;
        logic             c_q;
        logic             o_nx;
        logic             o_q;

        assign en = ld[k] & vin[k];

        if (k < NS) begin : g_add
            localparam int LO = k * CW;
            localparam int SW = (WIDTH - LO < CW) ? (WIDTH - LO) : CW;

            logic [SW-1:0] sl_sum;
            logic          sl_cout;
            logic          sl_cmsb;

            h_rca_slice #(.CW(SW)) u_slice (
                .a     (a_p[k][LO +: SW]),
                .b     (b_p[k][LO +: SW]),
                .cin   (c_p[k]),
                .sum   (sl_sum),
                .cout  (sl_cout),
                .c_msb (sl_cmsb)
            );

            // The top slice turns its carry into the result MSB and the overflow flag.
            always_comb begin
                s_nx             = s_p[k];
                s_nx[LO +: SW]   = sl_sum;
                c_nx             = sl_cout;
                o_nx             = o_p[k];
                if (k == NS - 1) begin
                    if (SIGNED != 0) begin
                        c_nx = a_p[k][WIDTH-1] ^ b_p[k][WIDTH-1] ^ sl_cout;
                        o_nx = sl_cmsb ^ sl_cout;
                    end else begin
                        o_nx = sl_cout;
                    end
                end
            end
        end else begin : g_pass
            always_comb begin
                s_nx = s_p[k];
                c_nx = c_p[k];
                o_nx = o_p[k];
            end
        end

        // Stage k -> k+1 boundary: de-skewed sum bits plus carry / result MSB.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                o_q <= 1'b0;
            end else if (en) begin
                s_q <= s_nx;
                c_q <= c_nx;
                o_q <= o_nx;
            end
        end

        assign s_p[k+1] = s_q;
        assign c_p[k+1] = c_q;
        assign o_p[k+1] = o_q;

        if (k < STAGES - 1) begin : g_skew
            localparam int LO = k * CW;

            logic [WIDTH-1:0] a_nx;
            logic [WIDTH-1:0] b_nx;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Consumed operand bits are dropped so the skew registers stay triangular.
            always_comb begin
                a_nx = a_p[k];
                b_nx = b_p[k];
                for (int i = 0; i < WIDTH; i++) begin
                    if (i >= LO && i < LO + CW) begin
                        a_nx[i] = 1'b0;
                        b_nx[i] = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_nx;
                    b_q <= b_nx;
                end
            end

            assign a_p[k+1] = a_q;
            assign b_p[k+1] = b_q;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_p[STAGES-1];
    assign out       = {c_p[STAGES], s_p[STAGES]};
    assign ovf       = o_p[STAGES];

endmodule

// File: tb/tb_h_rca_pipe.sv
// Directed bench for h_rca_pipe: 8-bit unsigned/signed instances with two stages,
// plus 5-bit unsigned instances with 1, 3, 4 and 5 stages.
module tb_h_rca_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_cin, u_ovf;
    logic [7:0] u_a, u_b;
    logic [8:0] u_out;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cin, s_ovf;
    logic [7:0] s_a, s_b;
    logic [8:0] s_out;

    logic       f_in_valid, f_out_ready, f_cin;
    logic [4:0] f_a, f_b;
    logic [3:0] f_in_ready, f_out_valid, f_ovf;
    logic [5:0] f_out [4];

    function automatic int f_stages(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    h_rca_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .a(u_a), .b(u_b), .cin(u_cin), .out_valid(u_out_valid),
        .out_ready(u_out_ready), .out(u_out), .ovf(u_ovf)
    );

    h_rca_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out(s_out), .ovf(s_ovf)
    );

    for (genvar g = 0; g < 4; g++) begin : g_w5
        h_rca_pipe #(.WIDTH(5), .STAGES(f_stages(g)), .SIGNED(0)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready[g]),
            .a(f_a), .b(f_b), .cin(f_cin), .out_valid(f_out_valid[g]),
            .out_ready(f_out_ready), .out(f_out[g]), .ovf(f_ovf[g])
        );
    end

    function automatic logic [7:0] stim_a(input int i);
        return 8'(i * 37 + 5);
    endfunction

    function automatic logic [7:0] stim_b(input int i);
        return 8'(250 - i * 13);
    endfunction

    function automatic logic [9:0] model_u(input int i);
        logic [8:0] sum;
        sum = 9'(stim_a(i)) + 9'(stim_b(i)) + 9'(i & 1);
        return {sum[8], sum};
    endfunction

    task automatic drain_u();
        u_in_valid  = 1'b0;
        u_out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        u_in_valid = 1'b0; u_out_ready = 1'b1; u_a = '0; u_b = '0; u_cin = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0;
        f_in_valid = 1'b0; f_out_ready = 1'b1; f_a = '0; f_b = '0; f_cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({u_out_valid, u_ovf, u_out} !== 11'd0) begin
            failures++;
            $display("FAIL reset_u valid=%b ovf=%b out=%h required all zero", u_out_valid, u_ovf, u_out);
        end
        checks++;
        if ({s_out_valid, s_ovf, s_out} !== 11'd0) begin
            failures++;
            $display("FAIL reset_s valid=%b ovf=%b out=%h required all zero", s_out_valid, s_ovf, s_out);
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if ({f_out_valid[g], f_ovf[g], f_out[g]} !== 8'd0) begin
                failures++;
                $display("FAIL reset_w5_%0d valid=%b ovf=%b out=%h required all zero", g, f_out_valid[g], f_ovf[g], f_out[g]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({u_in_ready, s_in_ready, f_in_ready} !== 6'h3F) begin
            failures++;
            $display("FAIL reset_in_ready got=%b%b%b required=111111", u_in_ready, s_in_ready, f_in_ready);
        end
    endtask

    task automatic test_unsigned();
        logic [7:0] va [4] = '{8'd200, 8'd255, 8'd0, 8'd15};
        logic [7:0] vb [4] = '{8'd100, 8'd255, 8'd0, 8'd1};
        logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [8:0] vo [4] = '{9'h12C, 9'h1FF, 9'h000, 9'h011};
        logic       vv [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int lat;
        drain_u();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            u_a = va[i]; u_b = vb[i]; u_cin = vc[i]; u_in_valid = 1'b1;
            @(posedge clk);
            #1 u_in_valid = 1'b0;
            lat = 1;
            while (u_out_valid !== 1'b1 && lat < 10) begin
                @(posedge clk);
                #1 lat++;
            end
            checks++;
            if (lat != 2 || u_out !== vo[i] || u_ovf !== vv[i]) begin
                failures++;
                $display("FAIL unsigned_%0d lat=%0d out=%h ovf=%b required lat=2 out=%h ovf=%b", i, lat, u_out, u_ovf, vo[i], vv[i]);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] va [6] = '{8'h9C, 8'h7F, 8'hFF, 8'h80, 8'h05, 8'hC0};
        logic [7:0] vb [6] = '{8'hCE, 8'h01, 8'h01, 8'h80, 8'hFA, 8'h10};
        logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] vo [6] = '{9'h16A, 9'h080, 9'h000, 9'h100, 9'h000, 9'h1D0};
        logic       vv [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int lat;
        s_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_a = va[i]; s_b = vb[i]; s_cin = vc[i]; s_in_valid = 1'b1;
            @(posedge clk);
            #1 s_in_valid = 1'b0;
            lat = 1;
            while (s_out_valid !== 1'b1 && lat < 10) begin
                @(posedge clk);
                #1 lat++;
            end
            checks++;
            if (lat != 2 || s_out !== vo[i] || s_ovf !== vv[i]) begin
                failures++;
                $display("FAIL signed_%0d lat=%0d out=%h ovf=%b required lat=2 out=%h ovf=%b", i, lat, s_out, s_ovf, vo[i], vv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        drain_u();
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            checks++;
            if (cyc >= 2 && cyc < 18) begin
                e = model_u(cyc - 2);
                if (u_out_valid !== 1'b1 || {u_ovf, u_out} !== e) begin
                    failures++;
                    $display("FAIL b2b_%0d valid=%b ovf=%b out=%h required valid=1 ovf=%b out=%h", cyc - 2, u_out_valid, u_ovf, u_out, e[9], e[8:0]);
                end
            end else if (u_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle cyc=%0d valid=%b required 0", cyc, u_out_valid);
            end
            if (cyc < 16) begin
                u_a = stim_a(cyc); u_b = stim_b(cyc); u_cin = 1'(cyc & 1); u_in_valid = 1'b1;
                #1 checks++;
                if (u_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready cyc=%0d got=%b required 1", cyc, u_in_ready);
                end
            end else begin
                u_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] q [$];
        logic [9:0] e;
        int sent = 0;
        int got  = 0;
        drain_u();
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            u_out_ready = (cyc >= 7);
            if (sent < 6) begin
                u_a = stim_a(sent + 20); u_b = stim_b(sent + 20); u_cin = 1'((sent + 20) & 1);
                u_in_valid = 1'b1;
            end else begin
                u_in_valid = 1'b0;
            end
            #1;
            if (cyc >= 2 && cyc < 7) begin
                e = model_u(20);
                checks++;
                if (u_in_ready !== 1'b0 || u_out_valid !== 1'b1 || {u_ovf, u_out} !== e) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d in_ready=%b valid=%b ovf=%b out=%h required in_ready=0 valid=1 ovf=%b out=%h", cyc, u_in_ready, u_out_valid, u_ovf, u_out, e[9], e[8:0]);
                end
            end
            if (u_out_valid === 1'b1 && u_out_ready === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra cyc=%0d out=%h required no result", cyc, u_out);
                end else begin
                    e = q.pop_front();
                    if ({u_ovf, u_out} !== e) begin
                        failures++;
                        $display("FAIL bp_order_%0d ovf=%b out=%h required ovf=%b out=%h", got, u_ovf, u_out, e[9], e[8:0]);
                    end
                end
                got++;
            end
            if (u_in_valid === 1'b1 && u_in_ready === 1'b1) begin
                q.push_back(model_u(sent + 20));
                sent++;
            end
        end
        checks++;
        if (got != 6 || sent != 6 || q.size() != 0) begin
            failures++;
            $display("FAIL bp_count sent=%0d got=%0d left=%0d required 6 6 0", sent, got, q.size());
        end
    endtask

    task automatic test_reset_mid();
        drain_u();
        u_out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            u_a = 8'h11; u_b = 8'h22; u_cin = 1'b0; u_in_valid = 1'b1;
        end
        @(negedge clk);
        u_in_valid = 1'b0;
        #1 checks++;
        if (u_out_valid !== 1'b1 || u_in_ready !== 1'b0 || u_out !== 9'h033) begin
            failures++;
            $display("FAIL rstmid_full valid=%b in_ready=%b out=%h required valid=1 in_ready=0 out=033", u_out_valid, u_in_ready, u_out);
        end
        rst_n = 1'b0;
        #1 checks++;
        if ({u_out_valid, u_ovf, u_out} !== 11'd0) begin
            failures++;
            $display("FAIL rstmid_async valid=%b ovf=%b out=%h required all zero", u_out_valid, u_ovf, u_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        u_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (u_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stale cyc=%0d valid=%b out=%h required valid=0", i, u_out_valid, u_out);
            end
        end
        checks++;
        if (u_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_in_ready got=%b required 1", u_in_ready);
        end
    endtask

    task automatic test_exhaustive_w5();
        int n = 2048;
        int m;
        logic [5:0] e;
        f_out_ready = 1'b1;
        f_in_valid  = 1'b0;
        repeat (2) @(negedge clk);
        for (int cyc = 0; cyc < n + 7; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                m = cyc - f_stages(g);
                checks++;
                if (m >= 0 && m < n) begin
                    e = 6'(m & 31) + 6'((m >> 5) & 31) + 6'((m >> 10) & 1);
                    if (f_out_valid[g] !== 1'b1 || f_out[g] !== e || f_ovf[g] !== e[5]) begin
                        failures++;
                        $display("FAIL w5_s%0d idx=%0d valid=%b out=%h ovf=%b required valid=1 out=%h ovf=%b", f_stages(g), m, f_out_valid[g], f_out[g], f_ovf[g], e, e[5]);
                    end
                end else if (f_out_valid[g] !== 1'b0) begin
                    failures++;
                    $display("FAIL w5_s%0d_idle cyc=%0d valid=%b required 0", f_stages(g), cyc, f_out_valid[g]);
                end
            end
            checks++;
            if (f_in_ready !== 4'hF) begin
                failures++;
                $display("FAIL w5_in_ready cyc=%0d got=%b required 1111", cyc, f_in_ready);
            end
            if (cyc < n) begin
                f_a = 5'(cyc); f_b = 5'(cyc >> 5); f_cin = 1'(cyc >> 10); f_in_valid = 1'b1;
            end else begin
                f_in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_exhaustive_w5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
